mdio_slave: RTL and testbench

MDIO management responder (PHY side) for IEEE 802.3 Clause 22 frames. It decodes frames issued by the team's MDIO master on the shared `mdio` line, holds a 32×16 register file, and answers read frames by driving the line during turnaround and data. It sits in the PHY/loopback model and in FPGA designs that expose a local management register bank to an external MDIO master.

---
 rtl/mdio_slave_if.sv | 28 ++
 rtl/mdio_slave.sv | 186 ++++++++++++++++++
 tb/tb_mdio_slave.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_slave_if.sv
// Local register-side bus of the MDIO responder.
//   status_in   : live value returned for reg 1
//   ctrl_reg    : current contents of reg 0
//   reg_wr      : one-cycle pulse when a write commits
//   reg_wr_addr : register address of the last committed write
//   reg_wr_data : data of the last committed write
//   busy        : a frame is being decoded
//   frame_err   : one-cycle pulse on a malformed frame
// modport slave is taken by mdio_slave; modport master by the user logic.
interface mdio_slave_if;
  logic [15:0] status_in;
  logic [15:0] ctrl_reg;
  logic        reg_wr;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        busy;
  logic        frame_err;

  modport slave (
    input  status_in,
    output ctrl_reg, reg_wr, reg_wr_addr, reg_wr_data, busy, frame_err
  );

  modport master (
    output status_in,
    input  ctrl_reg, reg_wr, reg_wr_addr, reg_wr_data, busy, frame_err
  );
endinterface

// File: rtl/mdio_slave.sv
// MDIO management responder (PHY side), IEEE 802.3 Clause 22.
// Decodes frames on the shared mdio line, holds a 32x16 register file and
// answers read frames by driving the line during TA bit 2 and the data bits.
// Ports:
//   mdc   : management clock, all logic on its rising edge
//   rst_n : asynchronous active-low reset
//   mdio  : shared open line (board pull-up, released line reads as 1)
//   bus   : register-side signals (see mdio_slave_if)
// Parameters: PHY_ADDR (responding address), PHY_ID1/PHY_ID2 (regs 2/3).
module mdio_slave #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1622
) (
  input  logic        mdc,
  input  logic        rst_n,
  inout  wire         mdio,
  mdio_slave_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  state_t      state, next_state;
  logic [5:0]  pre_cnt;
  logic [3:0]  bit_cnt;
  logic        op_hi;
  logic        is_read;
  logic        match;
  logic [4:0]  phy;
  logic [4:0]  regad;
  logic [15:0] rd_sh;
  logic [14:0] wr_sh;
  logic [15:0] regs [32];
  logic        mdio_oe;
  logic        mdio_out;

  logic        b;
  logic [4:0]  regad_full;
  logic [15:0] rd_word;
  logic        writable;
  logic        err_c;
  logic        last_c;
  logic        commit_c;

  assign b    = mdio;
  assign mdio = mdio_oe ? mdio_out : 1'bz;

  assign bus.ctrl_reg = regs[0];

  // Register address including the bit being sampled now; complete on the
  // last REGAD sample, which is when the read snapshot is taken.
  assign regad_full = {regad[3:0], b};
  assign writable   = (regad != 5'd1) && (regad != 5'd2) && (regad != 5'd3);
  assign commit_c   = last_c && !is_read && match && writable;

  always_comb begin
    rd_word = regs[regad_full];
    case (regad_full)
      5'd1:    rd_word = bus.status_in;
      5'd2:    rd_word = PHY_ID1;
      5'd3:    rd_word = PHY_ID2;
      default: rd_word = regs[regad_full];
    endcase
  end

  always_comb begin
    next_state = state;
    err_c      = 1'b0;
    last_c     = 1'b0;
    case (state)
      S_IDLE:  if (!b && pre_cnt == 6'd32) next_state = S_ST;
      S_ST: begin
        if (b) begin
          next_state = S_OP;
        end else begin
          next_state = S_IDLE;
          err_c      = 1'b1;
        end
      end
      S_OP: begin
        if (bit_cnt[0]) begin
          if (op_hi != b) begin
            next_state = S_PHYAD;
          end else begin
            next_state = S_IDLE;
            err_c      = 1'b1;
          end
        end
      end
      S_PHYAD: if (bit_cnt == 4'd4) next_state = S_REGAD;
      S_REGAD: if (bit_cnt == 4'd4) next_state = S_TA;
      S_TA:    if (bit_cnt[0])      next_state = S_DATA;
      S_DATA: begin
        if (bit_cnt == 4'd15) begin
          next_state = S_IDLE;
          last_c     = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge mdc or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge mdc or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt         <= '0;
      bit_cnt         <= '0;
      op_hi           <= 1'b0;
      is_read         <= 1'b0;
      match           <= 1'b0;
      phy             <= '0;
      regad           <= '0;
      rd_sh           <= '0;
      wr_sh           <= '0;
      mdio_oe         <= 1'b0;
      mdio_out        <= 1'b0;
      bus.reg_wr      <= 1'b0;
      bus.reg_wr_addr <= '0;
      bus.reg_wr_data <= '0;
      bus.busy        <= 1'b0;
      bus.frame_err   <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      bus.reg_wr    <= 1'b0;
      bus.frame_err <= err_c;
      bus.busy      <= (next_state != S_IDLE);
      bit_cnt       <= (next_state != state) ? '0 : bit_cnt + 4'd1;

      // Preamble counter only runs while staying in IDLE; any exit (and the
      // return from a frame) leaves it at 0 so a fresh preamble is needed.
      if (state == S_IDLE && next_state == S_IDLE)
        pre_cnt <= !b ? '0 : ((pre_cnt == 6'd32) ? pre_cnt : pre_cnt + 6'd1);
      else
        pre_cnt <= '0;

      case (state)
        S_OP: begin
          if (!bit_cnt[0]) op_hi   <= b;
          else             is_read <= op_hi & ~b;
        end
        S_PHYAD: phy <= {phy[3:0], b};
        S_REGAD: begin
          regad <= regad_full;
          if (bit_cnt == 4'd4) begin
            match <= (phy == PHY_ADDR);
            rd_sh <= rd_word;
          end
        end
        S_TA: begin
          if (is_read && match) begin
            if (!bit_cnt[0]) begin
              mdio_oe  <= 1'b1;
              mdio_out <= 1'b0;
            end else begin
              mdio_out <= rd_sh[15];
              rd_sh    <= {rd_sh[14:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          wr_sh <= {wr_sh[13:0], b};
          if (last_c) begin
            mdio_oe <= 1'b0;
          end else if (is_read && match) begin
            mdio_out <= rd_sh[15];
            rd_sh    <= {rd_sh[14:0], 1'b0};
          end
          if (commit_c) begin
            regs[regad]     <= {wr_sh, b};
            bus.reg_wr      <= 1'b1;
            bus.reg_wr_addr <= regad;
            bus.reg_wr_data <= {wr_sh, b};
          end
        end
        default: mdio_oe <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// Testbench for mdio_slave: acts as the MDIO master, changing the line on
// falling mdc. Expected commits and read words go into queues when a frame
// is issued; a monitor process compares them as the DUT produces them.
module tb_mdio_slave;
  logic        mdc = 1'b0;
  logic        rst_n;
  wire         mdio;
  logic        tb_oe;
  logic        tb_out;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  logic        busy_seen;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    int unsigned at;
  } wr_t;

  typedef struct {
    logic [15:0] data;
    logic        ta1;
    logic        ta2;
  } rd_t;

  wr_t wr_q[$];
  rd_t rd_exp_q[$];
  rd_t rd_obs_q[$];

  mdio_slave_if bus();

  pullup (mdio);
  assign mdio = tb_oe ? tb_out : 1'bz;

  mdio_slave #(
    .PHY_ADDR(5'd1),
    .PHY_ID1 (16'h0022),
    .PHY_ID2 (16'h1622)
  ) dut (
    .mdc  (mdc),
    .rst_n(rst_n),
    .mdio (mdio),
    .bus  (bus)
  );

  always #5 mdc = ~mdc;
  always @(posedge mdc) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic v);
    @(negedge mdc);
    tb_oe  = 1'b1;
    tb_out = v;
  endtask

  task automatic send(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic preamble();
    send('1, 32);
  endtask

  task automatic wr_frame(input logic [4:0] phy, input logic [4:0] ra,
                          input logic [15:0] d, input bit pre, input bit expect_wr);
    logic [31:0] f;
    wr_t e;
    f = {2'b01, 2'b01, phy, ra, 2'b10, d};
    if (pre) preamble();
    send({33'd0, f[31:1]}, 31);
    @(negedge mdc);
    if (expect_wr) begin
      e.addr = ra;
      e.data = d;
      e.at   = cyc + 1;
      wr_q.push_back(e);
    end
    tb_oe  = 1'b1;
    tb_out = f[0];
  endtask

  task automatic rd_frame(input logic [4:0] phy, input logic [4:0] ra,
                          input logic [15:0] d_exp, input logic ta2_exp);
    logic [13:0] h;
    rd_t e;
    rd_t o;
    h = {2'b01, 2'b10, phy, ra};
    preamble();
    send({50'd0, h}, 14);
    e.data = d_exp;
    e.ta1  = 1'b1;
    e.ta2  = ta2_exp;
    rd_exp_q.push_back(e);
    @(negedge mdc);
    tb_oe = 1'b0;
    #1 o.ta1 = mdio;
    @(negedge mdc);
    #1 o.ta2 = mdio;
    for (int i = 15; i >= 0; i--) begin
      @(negedge mdc);
      #1 o.data[i] = mdio;
    end
    rd_obs_q.push_back(o);
  endtask

  // Monitor / scoreboard
  initial begin
    wr_t e;
    rd_t re;
    rd_t ro;
    forever begin
      @(posedge mdc);
      #1;
      if (bus.busy) busy_seen = 1'b1;
      if (bus.reg_wr) begin
        if (wr_q.size() == 0) begin
          check("reg_wr_unexpected", 32'(bus.reg_wr), 32'd0);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", 32'(bus.reg_wr_addr), 32'(e.addr));
          check("wr_data", 32'(bus.reg_wr_data), 32'(e.data));
          check("wr_edge", cyc, e.at);
        end
      end
      while (rd_obs_q.size() > 0) begin
        ro = rd_obs_q.pop_front();
        if (rd_exp_q.size() == 0) begin
          check("rd_unexpected", 32'(rd_exp_q.size()), 32'd1);
        end else begin
          re = rd_exp_q.pop_front();
          check("rd_data", 32'(ro.data), 32'(re.data));
          check("rd_ta1", 32'(ro.ta1), 32'(re.ta1));
          check("rd_ta2", 32'(ro.ta2), 32'(re.ta2));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_oe         = 1'b0;
    tb_out        = 1'b1;
    bus.status_in = 16'h0000;
    busy_seen     = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge mdc);
    check("rst_ctrl_reg",    32'(bus.ctrl_reg),    32'd0);
    check("rst_reg_wr",      32'(bus.reg_wr),      32'd0);
    check("rst_reg_wr_addr", 32'(bus.reg_wr_addr), 32'd0);
    check("rst_reg_wr_data", 32'(bus.reg_wr_data), 32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_frame_err",   32'(bus.frame_err),   32'd0);
    check("rst_mdio",        32'(mdio),            32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge mdc);

    // Write reg 0, then read it back
    wr_frame(5'd1, 5'd0, 16'hA5C3, 1'b1, 1'b1);
    @(negedge mdc);
    check("wr_pulse_high", 32'(bus.reg_wr), 32'd1);
    check("ctrl_after_wr", 32'(bus.ctrl_reg), 32'hA5C3);
    check("busy_seen_wr",  32'(busy_seen), 32'd1);
    @(negedge mdc);
    check("wr_pulse_one_cycle", 32'(bus.reg_wr), 32'd0);
    check("busy_after_frame",   32'(bus.busy), 32'd0);
    rd_frame(5'd1, 5'd0, 16'hA5C3, 1'b0);

    // ID and status registers
    rd_frame(5'd1, 5'd2, 16'h0022, 1'b0);
    rd_frame(5'd1, 5'd3, 16'h1622, 1'b0);
    bus.status_in = 16'h782D;
    rd_frame(5'd1, 5'd1, 16'h782D, 1'b0);
    wr_frame(5'd1, 5'd2, 16'hFFFF, 1'b1, 1'b0);
    rd_frame(5'd1, 5'd2, 16'h0022, 1'b0);

    // Address mismatch
    wr_frame(5'd5, 5'd4, 16'h1234, 1'b1, 1'b0);
    rd_frame(5'd1, 5'd4, 16'h0000, 1'b0);
    rd_frame(5'd5, 5'd4, 16'hFFFF, 1'b1);

    // 31-bit preamble: frame must be ignored
    busy_seen = 1'b0;
    drive_bit(1'b0);
    send('1, 31);
    send({32'd0, 2'b01, 2'b01, 5'd1, 5'd6, 2'b10, 16'h5555}, 32);
    repeat (2) @(negedge mdc);
    check("short_pre_busy", 32'(busy_seen), 32'd0);
    rd_frame(5'd1, 5'd6, 16'h0000, 1'b0);

    // OP = 11
    preamble();
    send({60'd0, 4'b0111}, 4);
    @(negedge mdc);
    check("op11_frame_err", 32'(bus.frame_err), 32'd1);
    check("op11_busy",      32'(bus.busy),      32'd0);
    @(negedge mdc);
    check("op11_err_pulse", 32'(bus.frame_err), 32'd0);
    wr_frame(5'd1, 5'd9, 16'h0F0F, 1'b1, 1'b1);
    rd_frame(5'd1, 5'd9, 16'h0F0F, 1'b0);

    // Back-to-back frame without preamble
    wr_frame(5'd1, 5'd10, 16'h1111, 1'b1, 1'b1);
    wr_frame(5'd1, 5'd10, 16'h2222, 1'b0, 1'b0);
    rd_frame(5'd1, 5'd10, 16'h1111, 1'b0);

    // Reset during read data bit 7 (0x5A3C has bit 7 = 0, so the drive is visible)
    wr_frame(5'd1, 5'd0, 16'h5A3C, 1'b1, 1'b1);
    preamble();
    send({50'd0, 2'b01, 2'b10, 5'd1, 5'd0}, 14);
    @(negedge mdc);
    tb_oe = 1'b0;
    repeat (9) @(negedge mdc);
    @(negedge mdc);
    #1 check("abort_bit7_driven", 32'(mdio), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_mdio_released", 32'(mdio),            32'd1);
    check("abort_ctrl_reg",      32'(bus.ctrl_reg),    32'd0);
    check("abort_busy",          32'(bus.busy),        32'd0);
    check("abort_reg_wr",        32'(bus.reg_wr),      32'd0);
    check("abort_reg_wr_addr",   32'(bus.reg_wr_addr), 32'd0);
    check("abort_reg_wr_data",   32'(bus.reg_wr_data), 32'd0);
    check("abort_frame_err",     32'(bus.frame_err),   32'd0);
    @(negedge mdc);
    rst_n = 1'b1;
    rd_frame(5'd1, 5'd0, 16'h0000, 1'b0);
    rd_frame(5'd1, 5'd2, 16'h0022, 1'b0);
    wr_frame(5'd1, 5'd31, 16'hC0DE, 1'b1, 1'b1);
    rd_frame(5'd1, 5'd31, 16'hC0DE, 1'b0);

    repeat (4) @(negedge mdc);
    check("writes_drained", 32'(wr_q.size()),     32'd0);
    check("reads_drained",  32'(rd_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
